// File: rtl/arith_unit_byte_driver_if.sv
// Byte-stream and operand/result bundle between the arithmetic-unit host driver,
// the UART byte streams and the device under test.
interface arith_unit_byte_driver_if #(
    parameter int unsigned OPERAND_WIDTH = 8
);
    logic [7:0]               rx_data;
    logic                     rx_valid;
    logic                     rx_ready;
    logic [7:0]               tx_data;
    logic                     tx_valid;
    logic                     tx_ready;
    logic [1:0]               operation;
    logic [OPERAND_WIDTH-1:0] lhs;
    logic [OPERAND_WIDTH-1:0] rhs;
    logic [OPERAND_WIDTH-1:0] result;
    logic                     busy;

    modport master (
        input  rx_data, rx_valid, tx_ready, result,
        output rx_ready, tx_data, tx_valid, operation, lhs, rhs, busy
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, result,
        input  rx_ready, tx_data, tx_valid, operation, lhs, rhs, busy
    );
endinterface

// File: rtl/arith_unit_byte_driver.sv
// Host-side arithmetic-unit driver: byte command frames in, operands out, response frames back.
// Define ARITH_UNIT_BYTE_DRIVER_TIMEOUT_EN to abort a stalled partial frame with an 0xEE response.
module arith_unit_byte_driver #(
    parameter int unsigned OPERAND_WIDTH  = 8,
    parameter int unsigned SETTLE_CYCLES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    arith_unit_byte_driver_if.master  bus_io
);
    localparam int unsigned NB   = (OPERAND_WIDTH + 7) / 8;
    localparam int unsigned BW   = NB * 8;
    localparam int unsigned CntW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CntW-1:0] LastIdx    = CntW'(NB - 1);
    localparam logic [7:0]      LastSettle = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        StOpc, StLhs, StRhs, StSettle, StRespSt, StRespD, StErr
    } state_e;

    state_e                   state_q, state_d;
    logic [CntW-1:0]          cnt_q, cnt_d, cnt_inc;
    logic [7:0]               settle_q, settle_d;
    logic [1:0]               op_sh_q, op_sh_d;
    logic [BW-1:0]            lhs_sh_q, lhs_sh_d, rhs_sh_q, rhs_sh_d, resp_q, resp_d;
    logic [BW-1:0]            lhs_new, rhs_new;
    logic [1:0]               operation_q, operation_d;
    logic [OPERAND_WIDTH-1:0] lhs_q, lhs_d, rhs_q, rhs_d;
    logic [7:0]               tx_data_q, tx_data_d;
    logic                     tx_valid_q, tx_valid_d;
    logic                     rx_rdy, rx_fire, timeout;

    assign rx_rdy  = (state_q == StOpc) || (state_q == StLhs) || (state_q == StRhs);
    assign rx_fire = rx_rdy && bus_io.rx_valid;

`ifdef ARITH_UNIT_BYTE_DRIVER_TIMEOUT_EN
    logic [31:0] idle_q, idle_d;
    logic        mid_frame;

    assign mid_frame = (state_q == StLhs) || (state_q == StRhs);
    assign timeout   = mid_frame && !rx_fire && (idle_q == TIMEOUT_CYCLES - 1);

    // Reloads on every accepted byte; only runs while a frame is partially received.
    always_comb begin
        idle_d = '0;
        if (mid_frame && !rx_fire) idle_d = idle_q + 32'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) idle_q <= '0;
        else         idle_q <= idle_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout        = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cnt_inc     = cnt_q + 1'b1;
        settle_d    = settle_q;
        op_sh_d     = op_sh_q;
        lhs_sh_d    = lhs_sh_q;
        rhs_sh_d    = rhs_sh_q;
        resp_d      = resp_q;
        operation_d = operation_q;
        lhs_d       = lhs_q;
        rhs_d       = rhs_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        lhs_new     = lhs_sh_q;
        rhs_new     = rhs_sh_q;
        lhs_new[cnt_q * 8 +: 8] = bus_io.rx_data;
        rhs_new[cnt_q * 8 +: 8] = bus_io.rx_data;

        unique case (state_q)
            StOpc: begin
                if (rx_fire) begin
                    if (bus_io.rx_data[7:2] == 6'd0) begin
                        op_sh_d = bus_io.rx_data[1:0];
                        cnt_d   = '0;
                        state_d = StLhs;
                    end else begin
                        tx_valid_d = 1'b1;
                        tx_data_d  = 8'hEE;
                        state_d    = StErr;
                    end
                end
            end
            StLhs: begin
                if (rx_fire) begin
                    lhs_sh_d = lhs_new;
                    if (cnt_q == LastIdx) begin
                        cnt_d   = '0;
                        state_d = StRhs;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else if (timeout) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = 8'hEE;
                    state_d    = StErr;
                end
            end
            StRhs: begin
                if (rx_fire) begin
                    rhs_sh_d = rhs_new;
                    if (cnt_q == LastIdx) begin
                        // Commit all three together so the DUT never sees a half-loaded frame.
                        cnt_d       = '0;
                        operation_d = op_sh_q;
                        lhs_d       = lhs_sh_q[OPERAND_WIDTH-1:0];
                        rhs_d       = rhs_new[OPERAND_WIDTH-1:0];
                        settle_d    = '0;
                        state_d     = StSettle;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else if (timeout) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = 8'hEE;
                    state_d    = StErr;
                end
            end
            StSettle: begin
                if (settle_q == LastSettle) begin
                    resp_d                      = '0;
                    resp_d[OPERAND_WIDTH-1:0]   = bus_io.result;
                    settle_d                    = '0;
                    tx_valid_d                  = 1'b1;
                    tx_data_d                   = 8'h00;
                    state_d                     = StRespSt;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end
            StRespSt: begin
                if (bus_io.tx_ready) begin
                    tx_data_d = resp_q[7:0];
                    cnt_d     = '0;
                    state_d   = StRespD;
                end
            end
            StRespD: begin
                if (bus_io.tx_ready) begin
                    if (cnt_q == LastIdx) begin
                        tx_valid_d = 1'b0;
                        cnt_d      = '0;
                        state_d    = StOpc;
                    end else begin
                        tx_data_d = resp_q[cnt_inc * 8 +: 8];
                        cnt_d     = cnt_inc;
                    end
                end
            end
            StErr: begin
                if (bus_io.tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = StOpc;
                end
            end
            default: state_d = StOpc;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StOpc;
            cnt_q       <= '0;
            settle_q    <= '0;
            op_sh_q     <= '0;
            lhs_sh_q    <= '0;
            rhs_sh_q    <= '0;
            resp_q      <= '0;
            operation_q <= '0;
            lhs_q       <= '0;
            rhs_q       <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            settle_q    <= settle_d;
            op_sh_q     <= op_sh_d;
            lhs_sh_q    <= lhs_sh_d;
            rhs_sh_q    <= rhs_sh_d;
            resp_q      <= resp_d;
            operation_q <= operation_d;
            lhs_q       <= lhs_d;
            rhs_q       <= rhs_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
        end
    end

    assign bus_io.rx_ready  = rx_rdy;
    assign bus_io.tx_data   = tx_data_q;
    assign bus_io.tx_valid  = tx_valid_q;
    assign bus_io.operation = operation_q;
    assign bus_io.lhs       = lhs_q;
    assign bus_io.rhs       = rhs_q;
    assign bus_io.busy      = (state_q != StOpc);
endmodule

// File: tb/tb_arith_unit_byte_driver.sv
// Randomized frame-level bench for arith_unit_byte_driver (16-bit operands, 2 settle cycles).
// A stand-in arithmetic DUT drives result; responses are compared against a frame-level model.
module tb_arith_unit_byte_driver;
    localparam int unsigned W  = 16;
    localparam int unsigned S  = 2;
    localparam int unsigned TO = 50;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    arith_unit_byte_driver_if #(.OPERAND_WIDTH(W)) bus ();

    arith_unit_byte_driver #(
        .OPERAND_WIDTH (W),
        .SETTLE_CYCLES (S),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus_io(bus)
    );

    // Stand-in arithmetic unit: add, subtract, and, xor.
    function automatic logic [W-1:0] alu(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    assign bus.result = alu(bus.operation, bus.lhs, bus.rhs);

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc      = 0;
    bit         bp_hold  = 1'b0;
    logic [7:0] got_q[$];
    int         got_cyc_q[$];
    logic [7:0] exp_q[$];
    logic [1:0] exp_op  = '0;
    logic [W-1:0] exp_lhs = '0;
    logic [W-1:0] exp_rhs = '0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data  = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Sink side: picks tx_ready for the next edge, records transfers, checks hold under stall.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("tx_hold_valid", bus.tx_valid, 1);
                check("tx_hold_data", bus.tx_data, prev_data);
            end
            bus.tx_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (bus.tx_valid && bus.tx_ready) begin
                got_q.push_back(bus.tx_data);
                got_cyc_q.push_back(cyc + 1);
            end
            prev_stall = bus.tx_valid && !bus.tx_ready;
            prev_data  = bus.tx_data;
        end
    end

    // Offers a byte (rx_valid left high) and returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b, output int acc_cyc);
        int n = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (!bus.rx_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("rx_accept", bus.rx_ready, 1);
        acc_cyc = cyc + 1;
        @(negedge clk);
    endtask

    task automatic expect_resp(input string tag);
        int n = 0;
        while (got_q.size() < exp_q.size() && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_len"}, got_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (got_q.size() != 0) begin
                check($sformatf("%s_byte%0d", tag, i), got_q.pop_front(), exp_q[i]);
                void'(got_cyc_q.pop_front());
            end
        end
    endtask

    task automatic check_operands(input string tag);
        check({tag, "_op"}, bus.operation, exp_op);
        check({tag, "_lhs"}, bus.lhs, exp_lhs);
        check({tag, "_rhs"}, bus.rhs, exp_rhs);
    endtask

    task automatic run_frame(input logic [7:0] opb, input logic [W-1:0] a,
                             input logic [W-1:0] b, input bit bp);
        int acc;
        int n;
        logic [W-1:0] r;
        send_byte(opb, acc);
        if (opb[7:2] != 6'd0) begin
            bus.rx_valid = 1'b0;
            exp_q = '{8'hEE};
        end else begin
            send_byte(a[7:0], acc);
            send_byte(a[15:8], acc);
            send_byte(b[7:0], acc);
            send_byte(b[15:8], acc);
            bus.rx_valid = 1'b0;
            exp_op  = opb[1:0];
            exp_lhs = a;
            exp_rhs = b;
            check_operands("commit");
            check("busy_settle", bus.busy, 1);
            n = 1;
            while (!bus.tx_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("status_latency", n, S + 1);
            r = alu(exp_op, a, b);
            exp_q = '{8'h00, r[7:0], r[15:8]};
            if (bp) begin
                n = 0;
                while (got_q.size() < 2 && n < 100) begin
                    @(posedge clk);
                    n++;
                end
                bp_hold = 1'b1;
                @(negedge clk);
                for (int i = 0; i < 10; i++) begin
                    check("bp_tx_valid", bus.tx_valid, 1);
                    check("bp_rx_ready", bus.rx_ready, 0);
                    @(negedge clk);
                end
                bp_hold = 1'b0;
            end
        end
        expect_resp("resp");
        check_operands("hold");
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        exp_op  = '0;
        exp_lhs = '0;
        exp_rhs = '0;
        got_q.delete();
        got_cyc_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int acc;
        int acc2;
        int last_hs;
        logic [W-1:0] a1, b1, a2, b2, r1, r2;
        logic [7:0] opb;

        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        #1 rst_n = 1'b0;
        #2;
        check_operands("reset");
        check("reset_tx_valid", bus.tx_valid, 0);
        check("reset_tx_data", bus.tx_data, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_rx_ready", bus.rx_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Add frame: 0x1234 + 0x0001.
        run_frame(8'h00, 16'h1234, 16'h0001, 1'b0);

        // Bad opcode leaves committed operands alone; next frame runs normally.
        run_frame(8'h05, 16'h0, 16'h0, 1'b0);
        run_frame(8'h01, 16'h9000, 16'h0123, 1'b0);

        // Backpressure during the result bytes.
        run_frame(8'h02, 16'($urandom), 16'($urandom), 1'b1);

        for (int k = 0; k < 25; k++) begin
            if ($urandom_range(0, 4) == 0) opb = {6'($urandom_range(1, 63)), 2'($urandom)};
            else                           opb = {6'd0, 2'($urandom)};
            run_frame(opb, 16'($urandom), 16'($urandom), 1'b0);
        end

        // Back-to-back frames with rx_valid held high.
        a1 = 16'($urandom); b1 = 16'($urandom);
        a2 = 16'($urandom); b2 = 16'($urandom);
        send_byte(8'h00, acc);
        send_byte(a1[7:0], acc);
        send_byte(a1[15:8], acc);
        send_byte(b1[7:0], acc);
        send_byte(b1[15:8], acc);
        send_byte(8'h03, acc2);
        send_byte(a2[7:0], acc);
        send_byte(a2[15:8], acc);
        send_byte(b2[7:0], acc);
        send_byte(b2[15:8], acc);
        bus.rx_valid = 1'b0;
        last_hs = (got_cyc_q.size() >= 3) ? got_cyc_q[2] : 0;
        check("b2b_opc_after_resp", (got_cyc_q.size() >= 3) && (acc2 > last_hs), 1);
        r1 = a1 + b1;
        r2 = a2 ^ b2;
        exp_q = '{8'h00, r1[7:0], r1[15:8], 8'h00, r2[7:0], r2[15:8]};
        expect_resp("b2b");
        exp_op  = 2'd3;
        exp_lhs = a2;
        exp_rhs = b2;
        check_operands("b2b");

        // Mid-frame reset after three bytes clears outputs without waiting for a clock.
        send_byte(8'h00, acc);
        send_byte(8'h34, acc);
        send_byte(8'h12, acc);
        bus.rx_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        exp_op  = '0;
        exp_lhs = '0;
        exp_rhs = '0;
        check_operands("midrst");
        check("midrst_tx_valid", bus.tx_valid, 0);
        check("midrst_tx_data", bus.tx_data, 0);
        check("midrst_busy", bus.busy, 0);
        got_q.delete();
        got_cyc_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(8'h00, 16'h1234, 16'h0001, 1'b0);

        // Stalled partial frame.
        send_byte(8'h01, acc);
        send_byte(8'hFF, acc);
        bus.rx_valid = 1'b0;
        repeat (40) @(negedge clk);
        check("to_no_early_resp", got_q.size(), 0);
`ifdef ARITH_UNIT_BYTE_DRIVER_TIMEOUT_EN
        exp_q = '{8'hEE};
        expect_resp("timeout");
        check_operands("timeout");
`else
        repeat (20) @(negedge clk);
        check("no_timeout_resp", got_q.size(), 0);
        check("no_timeout_busy", bus.busy, 1);
`endif
        apply_reset();
        run_frame(8'h03, 16'($urandom), 16'($urandom), 1'b0);

        repeat (20) @(negedge clk);
        check("no_extra_tx", got_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1);
    end
endmodule
